// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer reader: FSM state encoding,
// Wishbone cycle-type tags and the pixel word size.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_BURST      = 2'd2
    } fb_state_e;

    localparam logic [2:0] CTI_NONE = 3'b000;
    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/fb_reader.sv
// Frame-buffer reader: fetches pixels from SDRAM with incrementing Wishbone
// read bursts and pushes each returned word into a downstream FIFO.
module fb_reader #(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter int          BURST_LEN = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        frame_start,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [31:0] wshb_adr,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    input  logic [31:0] wshb_dat_i,
    input  logic        wshb_ack,
    input  logic        wshb_err,
    input  logic        wshb_rty,
    output logic [31:0] fifo_wdata,
    output logic        fifo_write,
    input  logic        fifo_afull,
    output logic        frame_wrap,
    output logic [1:0]  fsm_state
);
    import fb_pkg::*;

    // Bus handshake: a beat completes in any cycle where cyc/stb are high and
    // the slave raises ack, err or rty; err/rty take priority over ack.

    localparam int NPIX   = HDISP * VDISP;
    localparam int IDX_W  = $clog2(NPIX);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NPIX - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    fb_state_e         state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  burst_base;
    logic [BEAT_W-1:0] beat;
    logic              pending;

    logic              in_burst;
    logic              fault;
    logic              beat_ok;
    logic              last_beat;
    logic [IDX_W-1:0]  idx_inc;

    assign in_burst  = (state == ST_BURST);
    assign fault     = in_burst && (wshb_err || wshb_rty);
    assign beat_ok   = in_burst && wshb_ack && !wshb_err && !wshb_rty;
    assign last_beat = (beat == LAST_BEAT);
    assign idx_inc   = (idx == LAST_IDX) ? '0 : idx + 1'b1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            burst_base <= '0;
            beat       <= '0;
            pending    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state <= ST_WAIT_SPACE;
                        idx   <= '0;
                    end
                end
                ST_WAIT_SPACE: begin
                    if (frame_start)
                        idx <= '0;
                    if (!fifo_afull) begin
                        state      <= ST_BURST;
                        beat       <= '0;
                        burst_base <= frame_start ? '0 : idx;
                    end
                end
                ST_BURST: begin
                    if (fault || (beat_ok && last_beat)) begin
                        state   <= ST_WAIT_SPACE;
                        beat    <= '0;
                        pending <= 1'b0;
                        // A restart request seen during the burst overrides both
                        // the rewind and the normal advance.
                        if (pending || frame_start)
                            idx <= '0;
                        else if (fault)
                            idx <= burst_base;
                        else
                            idx <= idx_inc;
                    end else begin
                        if (frame_start)
                            pending <= 1'b1;
                        if (beat_ok) begin
                            idx  <= idx_inc;
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wshb_cyc   = in_burst;
    assign wshb_stb   = in_burst;
    assign wshb_we    = 1'b0;
    assign wshb_sel   = 4'hF;
    assign wshb_bte   = 2'b00;
    assign wshb_cti   = in_burst ? (last_beat ? CTI_EOB : CTI_INCR) : CTI_NONE;
    assign wshb_adr   = BASE_ADDR + 32'(idx) * WORD_BYTES;
    assign fifo_write = beat_ok;
    assign fifo_wdata = wshb_dat_i;
    assign frame_wrap = beat_ok && (idx == LAST_IDX);
    assign fsm_state  = state;

endmodule

// File: tb/tb_fb_reader.sv
// Self-checking bench for fb_reader: Wishbone slave stub, pixel-pointer
// reference model with a data scoreboard, directed scenarios and a random soak.
module tb_fb_reader;
    localparam int          HDISP = 8;
    localparam int          VDISP = 2;
    localparam int          BL    = 4;
    localparam int          NPIX  = HDISP * VDISP;
    localparam logic [31:0] BASE  = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        cyc, stb, we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat = '0;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic [31:0] wdata;
    logic        fwrite;
    logic        afull = 1'b0;
    logic        fwrap;
    logic [1:0]  fsm_state;

    fb_reader #(.HDISP(HDISP), .VDISP(VDISP), .BURST_LEN(BL), .BASE_ADDR(BASE)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .frame_start(frame_start),
        .wshb_cyc(cyc), .wshb_stb(stb), .wshb_we(we), .wshb_adr(adr),
        .wshb_sel(sel), .wshb_cti(cti), .wshb_bte(bte), .wshb_dat_i(dat),
        .wshb_ack(ack), .wshb_err(err), .wshb_rty(rty),
        .fifo_wdata(wdata), .fifo_write(fwrite), .fifo_afull(afull),
        .frame_wrap(fwrap), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // stimulus knobs
    int          wait_mode = 0;     // 0: zero wait, 1: three waits, 2: random 0..3
    bit          rand_term = 1'b0;  // random err/rty/err+ack terminations
    bit          rand_fs   = 1'b0;  // random frame_start pulses
    bit          fs_pend   = 1'b0;
    bit          err_arm   = 1'b0;
    logic [31:0] err_adr   = '0;
    bit          fs_arm    = 1'b0;
    logic [31:0] fs_adr    = '0;

    // slave stub state
    int sbeat = 0, wcnt = 0, wtarget = 0;
    int n_acks = 0, n_writes = 0;

    // scoreboard and reference model
    logic [31:0] exp_q[$];
    logic [31:0] log_adr[$];
    logic [2:0]  log_cti[$];
    logic        log_wrap[$];
    int          m_ptr = 0, m_start = 0, m_beat = 0;
    bit          m_pend = 1'b0, m_in = 1'b0, m_end = 1'b0;

    function automatic int pick_wait();
        case (wait_mode)
            0:       return 0;
            1:       return 3;
            default: return int'($urandom_range(0, 3));
        endcase
    endfunction

    // ---------------- driver: slave stub, runs 1 time unit after posedge ----------------
    task automatic drive_bus();
        int r;
        frame_start = fs_pend;
        fs_pend     = 1'b0;
        ack = 1'b0; err = 1'b0; rty = 1'b0;
        if (rand_fs && $urandom_range(0, 149) == 0) frame_start = 1'b1;
        if (rst_n && cyc && stb) begin
            if (fs_arm && adr == fs_adr) begin
                frame_start = 1'b1;
                fs_arm      = 1'b0;
            end
            if (wcnt < wtarget) begin
                wcnt++;
            end else begin
                wcnt    = 0;
                wtarget = pick_wait();
                r       = rand_term ? int'($urandom_range(0, 19)) : 99;
                if (err_arm && adr == err_adr) begin
                    err     = 1'b1;
                    err_arm = 1'b0;
                end else if (r == 0) begin
                    err = 1'b1;
                end else if (r == 1) begin
                    rty = 1'b1;
                end else if (r == 2) begin
                    err = 1'b1;
                    ack = 1'b1;
                    dat = $urandom;
                end else begin
                    ack = 1'b1;
                    dat = $urandom;
                    exp_q.push_back(dat);
                    n_acks++;
                    sbeat++;
                end
            end
        end else begin
            wcnt    = 0;
            wtarget = pick_wait();
            sbeat   = 0;
        end
    endtask

    // ---------------- compare process body: runs on negedge ----------------
    task automatic compare();
        bit          exp_w;
        logic [31:0] exp_d;
        if (!rst_n) begin
            check("rst_cyc", {31'b0, cyc}, 32'd0);
            check("rst_write", {31'b0, fwrite}, 32'd0);
            check("rst_wrap", {31'b0, fwrap}, 32'd0);
            check("rst_cti", {29'b0, cti}, 32'd0);
            m_ptr = 0; m_pend = 1'b0; m_in = 1'b0; m_end = 1'b0;
            return;
        end
        if (m_end) begin
            check("cyc_drop", {31'b0, cyc}, 32'd0);
            m_end = 1'b0;
        end
        if (cyc && !m_in) begin
            m_in = 1'b1; m_start = m_ptr; m_beat = 0;
        end
        if (fwrite) n_writes++;
        if (!cyc) begin
            if (m_in) begin
                check("cyc_hold", {31'b0, cyc}, 32'd1);
                m_in = 1'b0;
            end
            check("idle_write", {31'b0, fwrite}, 32'd0);
            check("idle_wrap", {31'b0, fwrap}, 32'd0);
            if (frame_start) m_ptr = 0;
            return;
        end
        exp_w = ack && !err && !rty;
        check("stb", {31'b0, stb}, 32'd1);
        check("adr", adr, BASE + 32'(m_ptr) * 32'd4);
        check("cti", {29'b0, cti}, (m_beat == BL - 1) ? 32'd7 : 32'd2);
        check("write", {31'b0, fwrite}, {31'b0, exp_w});
        check("wrap", {31'b0, fwrap}, {31'b0, exp_w && (m_ptr == NPIX - 1)});
        if (exp_w) begin
            if (exp_q.size() == 0) begin
                check("exp_q_empty", 32'd0, 32'd1);
            end else begin
                exp_d = exp_q.pop_front();
                check("wdata", wdata, exp_d);
            end
            log_adr.push_back(adr);
            log_cti.push_back(cti);
            log_wrap.push_back(fwrap);
        end
        if (err || rty) begin
            m_ptr = (m_pend || frame_start) ? 0 : m_start;
            m_pend = 1'b0; m_in = 1'b0; m_end = 1'b1;
        end else if (ack) begin
            m_ptr = (m_ptr + 1) % NPIX;
            m_beat++;
            if (m_beat == BL) begin
                if (m_pend || frame_start) m_ptr = 0;
                m_pend = 1'b0; m_in = 1'b0; m_end = 1'b1;
            end else if (frame_start) begin
                m_pend = 1'b1;
            end
        end else if (frame_start) begin
            m_pend = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_bus();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) step();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic clear_logs();
        log_adr.delete(); log_cti.delete(); log_wrap.delete();
    endtask

    task automatic drain();
        int quiet = 0;
        afull = 1'b1; rand_fs = 1'b0; rand_term = 1'b0;
        for (int i = 0; i < 400 && quiet < 6; i++) begin
            step();
            quiet = cyc ? 0 : quiet + 1;
        end
        check("drain_timeout", {31'b0, cyc}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          n;
        bit          seen;
        logic [31:0] seq[15];
        seq = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114,
                32'h110, 32'h114, 32'h118, 32'h11C,
                32'h120, 32'h124, 32'h128, 32'h12C, 32'h100};

        // reset values
        do_reset(3);
        check("rst_we", {31'b0, we}, 32'd0);
        check("rst_sel", {28'b0, sel}, 32'hF);
        check("rst_bte", {30'b0, bte}, 32'd0);
        check("rst_state", {30'b0, fsm_state}, {30'b0, fb_pkg::ST_IDLE});
        seen = 1'b0;
        repeat (5) begin step(); seen |= cyc; end
        check("idle_before_start", {31'b0, seen}, 32'd0);

        // always-ack frame walk: 17 writes across a frame wrap
        clear_logs();
        fs_pend = 1'b1;
        n = 0;
        while (log_adr.size() < 17 && n < 200) begin step(); n++; end
        check("walk_timeout", {31'b0, log_adr.size() >= 17}, 32'd1);
        if (log_adr.size() >= 17) begin
            check("walk_first", log_adr[0], 32'h100);
            check("walk_last", log_adr[15], 32'h13C);
            check("walk_wrap_adr", log_adr[16], 32'h100);
            n = 0;
            for (int i = 0; i < 17; i++) begin
                if (log_adr[i] !== 32'h100 + 32'(i % 16) * 32'd4) n++;
                if (log_cti[i] !== ((i % 4 == 3) ? 3'b111 : 3'b010)) n++;
                if (log_wrap[i] !== (i == 15)) n++;
            end
            check("walk_pattern_errors", 32'(n), 32'd0);
        end

        // fifo_afull hold-off and release latency
        drain();
        seen = 1'b0;
        repeat (10) begin step(); seen |= cyc; end
        check("afull_holdoff", {31'b0, seen}, 32'd0);
        afull = 1'b0;
        n = 0;
        while (!cyc && n < 10) begin step(); n++; end
        check("afull_release_le2", {31'b0, n <= 2 && cyc}, 32'd1);

        // err on beat 2 at 0x110, then frame_start during beat 1 at 0x120
        drain();
        do_reset(2);
        afull = 1'b0;
        err_adr = 32'h118; err_arm = 1'b1;
        fs_adr  = 32'h124; fs_arm  = 1'b1;
        clear_logs();
        fs_pend = 1'b1;
        n = 0;
        while (log_adr.size() < 15 && n < 300) begin step(); n++; end
        check("seq_timeout", {31'b0, log_adr.size() >= 15}, 32'd1);
        if (log_adr.size() >= 15) begin
            n = 0;
            for (int i = 0; i < 15; i++) if (log_adr[i] !== seq[i]) n++;
            check("err_fs_seq_errors", 32'(n), 32'd0);
            check("err_restart_adr", log_adr[6], 32'h110);
            check("fs_next_burst_adr", log_adr[14], 32'h100);
        end

        // three wait states per beat
        wait_mode = 1;
        n_acks = 0; n_writes = 0;
        repeat (200) step();
        drain();
        check("wait_ack_vs_write", 32'(n_writes), 32'(n_acks));
        check("wait_q_empty", 32'(exp_q.size()), 32'd0);

        // random soak
        wait_mode = 2;
        afull = 1'b0;
        fs_pend = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rand_term = 1'b1; rand_fs = 1'b1;
            if (i % 7 == 0) afull = ($urandom_range(0, 3) == 0);
            step();
        end
        drain();
        check("soak_q_empty", 32'(exp_q.size()), 32'd0);

        // reset asserted during beat 2
        wait_mode = 0;
        afull = 1'b0;
        fs_pend = 1'b1;
        n = 0;
        while (!(cyc && sbeat == 2) && n < 100) begin step(); n++; end
        check("beat2_timeout", {31'b0, cyc && sbeat == 2}, 32'd1);
        @(posedge clk);
        #1;
        ack = 1'b0; err = 1'b0; rty = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_cyc", {31'b0, cyc}, 32'd0);
        check("async_rst_write", {31'b0, fwrite}, 32'd0);
        @(negedge clk);
        compare();
        do_reset(3);
        seen = 1'b0;
        repeat (20) begin step(); seen |= cyc; end
        check("idle_after_rst", {31'b0, seen}, 32'd0);
        fs_pend = 1'b1;
        n = 0;
        while (!cyc && n < 10) begin step(); n++; end
        check("restart_adr", adr, 32'h100);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
